enemy_hit: RTL

Receiving end of the player attack interface: consumes the attack object (on flag, anchor position, direction), tests its hitbox against one enemy's 16x16 box once per game frame, and owns that enemy's health and life-cycle state machine. One instance per enemy. Outputs feed the enemy sprite renderer (visibility, flash) and the score/spawn logic (hit and kill pulses).

---
 rtl/boxhead_pkg.sv | 25 ++
 rtl/attack_box_overlap.sv | 73 +++++++
 rtl/enemy_hit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/boxhead_pkg.sv
// Shared definitions for the boxhead game blocks: enemy life-cycle states,
// attack directions and attack hitbox dimensions.
package boxhead_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HURT  = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } enemy_state_t;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [9:0] ATTACK_SHORT = 10'd16;
    localparam logic [9:0] ATTACK_LONG  = 10'd80;

    // Subtract without wrapping below zero; used for hitbox lower bounds.
    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : 10'd0;
    endfunction

endpackage

// File: rtl/attack_box_overlap.sv
// Combinational test of a directional attack hitbox against a square target
// box; all arithmetic is 10-bit unsigned with half-open intervals.
module attack_box_overlap
    import boxhead_pkg::*;
(
    input  logic [8:0] i_attack_x,
    input  logic [8:0] i_attack_y,
    input  logic [1:0] i_attack_dir,
    input  logic [8:0] i_target_x,
    input  logic [8:0] i_target_y,
    input  logic [9:0] i_target_size,
    output logic       o_overlap
);

    logic [9:0] w_ax;
    logic [9:0] w_ay;
    logic [9:0] w_tx_lo;
    logic [9:0] w_ty_lo;
    logic [9:0] w_tx_hi;
    logic [9:0] w_ty_hi;
    logic [9:0] w_x_lo;
    logic [9:0] w_x_hi;
    logic [9:0] w_y_lo;
    logic [9:0] w_y_hi;
    logic       w_x_ovl;
    logic       w_y_ovl;

    assign w_ax    = {1'b0, i_attack_x};
    assign w_ay    = {1'b0, i_attack_y};
    assign w_tx_lo = {1'b0, i_target_x};
    assign w_ty_lo = {1'b0, i_target_y};
    assign w_tx_hi = w_tx_lo + i_target_size;
    assign w_ty_hi = w_ty_lo + i_target_size;

    always_comb begin
        w_x_lo = w_ax;
        w_x_hi = w_ax + ATTACK_SHORT;
        w_y_lo = w_ay;
        w_y_hi = w_ay + ATTACK_LONG;
        case (i_attack_dir)
            DIR_LEFT: begin
                w_x_lo = sat_sub(w_ax, ATTACK_LONG);
                w_x_hi = w_ax;
                w_y_lo = w_ay;
                w_y_hi = w_ay + ATTACK_SHORT;
            end
            DIR_UP: begin
                w_x_lo = w_ax;
                w_x_hi = w_ax + ATTACK_SHORT;
                w_y_lo = sat_sub(w_ay, ATTACK_LONG);
                w_y_hi = w_ay;
            end
            DIR_RIGHT: begin
                w_x_lo = w_ax;
                w_x_hi = w_ax + ATTACK_LONG;
                w_y_lo = w_ay;
                w_y_hi = w_ay + ATTACK_SHORT;
            end
            default: begin
                w_x_lo = w_ax;
                w_x_hi = w_ax + ATTACK_SHORT;
                w_y_lo = w_ay;
                w_y_hi = w_ay + ATTACK_LONG;
            end
        endcase
    end

    // Strict interval intersection: edge contact or an empty hitbox is a miss.
    assign w_x_ovl   = (w_x_lo < w_tx_hi) && (w_tx_lo < w_x_hi);
    assign w_y_ovl   = (w_y_lo < w_ty_hi) && (w_ty_lo < w_y_hi);
    assign o_overlap = w_x_ovl && w_y_ovl;

endmodule

// File: rtl/enemy_hit.sv
// One enemy's hit detection, health and ALIVE/HURT/DYING/DEAD life cycle,
// advanced on the game frame strobe; Respawn is honoured on any cycle.
module enemy_hit
    import boxhead_pkg::*;
#(
    parameter int ENEMY_SIZE    = 16,
    parameter int MAX_HEALTH    = 8,
    parameter int DAMAGE        = 2,
    parameter int INVULN_FRAMES = 8,
    parameter int DEATH_FRAMES  = 16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         game_frame_clk_rising_edge,
    input  logic         Attack_On,
    input  logic [8:0]   Attack_X,
    input  logic [8:0]   Attack_Y,
    input  logic [1:0]   Attack_Direction,
    input  logic [8:0]   Enemy_X,
    input  logic [8:0]   Enemy_Y,
    input  logic         Respawn,
    output logic [3:0]   Enemy_Health,
    output logic         Enemy_Alive,
    output logic         Enemy_Visible,
    output logic         Enemy_Flash,
    output logic         Hit_Pulse,
    output logic         Kill_Pulse,
    output enemy_state_t Enemy_State
);

    localparam logic [9:0] L_SIZE   = 10'(ENEMY_SIZE);
    localparam logic [3:0] L_MAX    = 4'(MAX_HEALTH);
    localparam logic [3:0] L_DMG    = 4'(DAMAGE);
    localparam logic [4:0] L_INV_LD = 5'(INVULN_FRAMES - 1);
    localparam logic [4:0] L_DIE_LD = 5'(DEATH_FRAMES - 1);

    enemy_state_t r_state;
    logic [4:0]   r_cnt;
    logic [3:0]   r_health;
    logic         r_hit;
    logic         r_kill;
    logic         r_flash;
    logic         r_alive;
    logic         r_visible;

    logic         w_overlap;
    logic         w_hit;
    logic [3:0]   w_dmg_health;
    enemy_state_t w_nstate;
    logic [4:0]   w_ncnt;
    logic [3:0]   w_nhealth;
    logic         w_nhit;
    logic         w_nkill;
    logic         w_nflash;

    attack_box_overlap u_overlap (
        .i_attack_x    (Attack_X),
        .i_attack_y    (Attack_Y),
        .i_attack_dir  (Attack_Direction),
        .i_target_x    (Enemy_X),
        .i_target_y    (Enemy_Y),
        .i_target_size (L_SIZE),
        .o_overlap     (w_overlap)
    );

    assign w_hit        = game_frame_clk_rising_edge & Attack_On & w_overlap;
    assign w_dmg_health = (r_health > L_DMG) ? (r_health - L_DMG) : 4'd0;

    always_comb begin
        w_nstate  = r_state;
        w_ncnt    = r_cnt;
        w_nhealth = r_health;
        w_nhit    = 1'b0;
        w_nkill   = 1'b0;
        if (Respawn) begin
            w_nstate  = ALIVE;
            w_ncnt    = 5'd0;
            w_nhealth = L_MAX;
        end else if (game_frame_clk_rising_edge) begin
            case (r_state)
                ALIVE: begin
                    if (w_hit) begin
                        w_nhealth = w_dmg_health;
                        w_nhit    = 1'b1;
                        if (w_dmg_health == 4'd0) begin
                            w_nstate = DYING;
                            w_ncnt   = L_DIE_LD;
                        end else begin
                            w_nstate = HURT;
                            w_ncnt   = L_INV_LD;
                        end
                    end
                end
                // Invulnerable: hits are ignored, including on the exit strobe.
                HURT: begin
                    if (r_cnt == 5'd0) begin
                        w_nstate = ALIVE;
                    end else begin
                        w_ncnt = r_cnt - 5'd1;
                    end
                end
                DYING: begin
                    if (r_cnt == 5'd0) begin
                        w_nstate = DEAD;
                        w_nkill  = 1'b1;
                    end else begin
                        w_ncnt = r_cnt - 5'd1;
                    end
                end
                default: begin
                    w_nstate = r_state;
                end
            endcase
        end
    end

    always_comb begin
        w_nflash = 1'b0;
        case (w_nstate)
            HURT:    w_nflash = w_ncnt[1];
            DYING:   w_nflash = w_ncnt[2];
            default: w_nflash = 1'b0;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ALIVE;
            r_cnt     <= 5'd0;
            r_health  <= L_MAX;
            r_hit     <= 1'b0;
            r_kill    <= 1'b0;
            r_flash   <= 1'b0;
            r_alive   <= 1'b1;
            r_visible <= 1'b1;
        end else begin
            r_state   <= w_nstate;
            r_cnt     <= w_ncnt;
            r_health  <= w_nhealth;
            r_hit     <= w_nhit;
            r_kill    <= w_nkill;
            r_flash   <= w_nflash;
            r_alive   <= (w_nstate == ALIVE) || (w_nstate == HURT);
            r_visible <= (w_nstate != DEAD);
        end
    end

    assign Enemy_Health  = r_health;
    assign Enemy_Alive   = r_alive;
    assign Enemy_Visible = r_visible;
    assign Enemy_Flash   = r_flash;
    assign Hit_Pulse     = r_hit;
    assign Kill_Pulse    = r_kill;
    assign Enemy_State   = r_state;

endmodule
